stack_arbiter: RTL and testbench

Two-port arbiter and sequencer for an on-chip LIFO buffer. Two requesters each issue push or pop operations through a req/gnt handshake. The block grants at most one operation per cycle using round-robin priority, and rejects pushes when full and pops when empty. A flush command drains the stack one entry per cycle onto a dedicated drain port. The block sits between client logic and its private LIFO storage (sub-module `lifo_core`), so no client drives stack pointers directly.

---
 rtl/stack_pkg.sv | 12 +
 rtl/lifo_core.sv | 51 +++++
 rtl/stack_arbiter.sv | 145 ++++++++++++++
 tb/tb_stack_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared opcodes and FSM state encoding for the stack arbiter slice.
package stack_pkg;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/lifo_core.sv
// Private LIFO storage: memory array plus occupancy pointer.
// The caller never asserts push and pop in the same cycle.
module lifo_core #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              do_push,
  input  logic              do_pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [PTR_W-1:0]  w_top_idx;
  logic              w_full;
  logic              w_empty;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_wr_idx  = r_count[PTR_W-1:0];
  assign w_top_idx = w_wr_idx - PTR_W'(1);
  assign top       = r_mem[w_top_idx];
  assign count     = r_count;

  // Occupancy pointer; illegal moves are suppressed instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (do_push && !w_full) begin
      r_count <= r_count + CNT_W'(1);
    end else if (do_pop && !w_empty) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Entry storage; contents survive reset, only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (do_push && !w_full) begin
      r_mem[w_wr_idx] <= din;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Two-requester round-robin arbiter and flush sequencer in front of lifo_core.
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req,
  input  logic [1:0]          op,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          err,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rvalid,
  input  logic                flush,
  output logic                busy,
  output logic [DATA_W-1:0]   drain_data,
  output logic                drain_valid,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                empty
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last;
  logic [1:0]        r_err;
  logic [1:0]        r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_drain_data;
  logic              r_drain_valid;

  logic [1:0]        w_gnt;
  logic              w_sel;
  logic              w_do_push;
  logic              w_do_pop;
  logic              w_drain;
  logic [1:0]        w_err;
  logic [1:0]        w_rvalid;
  logic [DATA_W-1:0] w_din;
  logic [DATA_W-1:0] w_top;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;

  assign w_full  = (w_count == CNT_W'(DEPTH));
  assign w_empty = (w_count == '0);
  assign w_din   = w_sel ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];

  lifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_lifo (
    .clk     (clk),
    .reset   (reset),
    .do_push (w_do_push),
    .do_pop  (w_do_pop),
    .din     (w_din),
    .top     (w_top),
    .count   (w_count)
  );

  // Next state, grant selection and commit decisions for the current cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = '0;
    w_sel       = 1'b0;
    w_do_push   = 1'b0;
    w_do_pop    = 1'b0;
    w_drain     = 1'b0;
    w_err       = '0;
    w_rvalid    = '0;
    case (r_state)
      ST_IDLE: begin
        if (flush && !w_empty) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          case (req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
            default: w_gnt = 2'b00;
          endcase
          w_sel = w_gnt[1];
          if (w_gnt != 2'b00) begin
            if (op[w_sel] == OP_PUSH) begin
              if (w_full) w_err     = w_gnt;
              else        w_do_push = 1'b1;
            end else begin
              if (w_empty) begin
                w_err = w_gnt;
              end else begin
                w_do_pop = 1'b1;
                w_rvalid = w_gnt;
              end
            end
          end
        end
      end
      ST_FLUSH: begin
        w_do_pop = 1'b1;
        w_drain  = 1'b1;
        if (w_count == CNT_W'(1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, round-robin pointer and all registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_last        <= 1'b1;
      r_err         <= '0;
      r_rvalid      <= '0;
      r_rdata       <= '0;
      r_drain_data  <= '0;
      r_drain_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_err         <= w_err;
      r_rvalid      <= w_rvalid;
      r_drain_valid <= w_drain;
      if (w_gnt != 2'b00) r_last       <= w_sel;
      if (w_rvalid != '0) r_rdata      <= w_top;
      if (w_drain)        r_drain_data <= w_top;
    end
  end

  assign gnt         = w_gnt;
  assign err         = r_err;
  assign rvalid      = r_rvalid;
  assign rdata       = r_rdata;
  assign busy        = (r_state == ST_FLUSH);
  assign drain_data  = r_drain_data;
  assign drain_valid = r_drain_valid;
  assign count       = w_count;
  assign full        = w_full;
  assign empty       = w_empty;

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter: reference stack model plus response queues.
module tb_stack_arbiter;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [1:0]          req = '0;
  logic [1:0]          op = '0;
  logic [2*DATA_W-1:0] wdata = '0;
  logic                flush = 1'b0;
  logic [1:0]          gnt;
  logic [1:0]          err;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rvalid;
  logic                busy;
  logic [DATA_W-1:0]   drain_data;
  logic                drain_valid;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                empty;

  stack_arbiter #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .op          (op),
    .wdata       (wdata),
    .gnt         (gnt),
    .err         (err),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .flush       (flush),
    .busy        (busy),
    .drain_data  (drain_data),
    .drain_valid (drain_valid),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rv;
    logic [1:0] er;
    logic [7:0] rd;
  } resp_t;

  int         n_checks = 0;
  int         n_errors = 0;
  logic       mon_en = 1'b0;
  resp_t      rq[$];
  logic [7:0] dq[$];
  logic [7:0] m_stk[$];
  logic       m_last = 1'b1;
  logic [7:0] m_rdata = '0;
  resp_t      mon_e;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Registered responses are compared on the falling edge against queued expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rvalid !== 2'b00 || err !== 2'b00) begin
        if (rq.size() == 0) begin
          chk("spurious_resp", {28'd0, rvalid, err}, 32'd0);
        end else begin
          mon_e = rq.pop_front();
          chk("rvalid", {30'd0, rvalid}, {30'd0, mon_e.rv});
          chk("err", {30'd0, err}, {30'd0, mon_e.er});
          chk("rdata", {24'd0, rdata}, {24'd0, mon_e.rd});
        end
      end
      if (drain_valid !== 1'b0) begin
        if (dq.size() == 0) chk("spurious_drain", {31'd0, drain_valid}, 32'd0);
        else                chk("drain_data", {24'd0, drain_data}, {24'd0, dq.pop_front()});
      end
    end
  end

  task automatic chk_occ();
    chk("count", {28'd0, count}, m_stk.size());
    chk("full", {31'd0, full}, {31'd0, m_stk.size() == DEPTH});
    chk("empty", {31'd0, empty}, {31'd0, m_stk.size() == 0});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    m_stk.delete(); m_last = 1'b1; m_rdata = '0;
    chk("rst_gnt", {30'd0, gnt}, 0);
    chk("rst_err", {30'd0, err}, 0);
    chk("rst_rvalid", {30'd0, rvalid}, 0);
    chk("rst_rdata", {24'd0, rdata}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_drain_data", {24'd0, drain_data}, 0);
    chk("rst_drain_valid", {31'd0, drain_valid}, 0);
    chk("rst_pending", rq.size() + dq.size(), 0);
    chk_occ();
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  // One IDLE-state cycle: drive, compare the grant with the model, record expectations.
  task automatic drive(input logic [1:0] r, input logic [1:0] o,
                       input logic [7:0] d0, input logic [7:0] d1);
    logic [1:0] eg;
    logic       i;
    resp_t      e;
    @(negedge clk); #1;
    chk_occ();
    chk("busy_idle", {31'd0, busy}, 0);
    req = r; op = o; wdata = {d1, d0}; flush = 1'b0;
    #1;
    case (r)
      2'b01:   eg = 2'b01;
      2'b10:   eg = 2'b10;
      2'b11:   eg = m_last ? 2'b01 : 2'b10;
      default: eg = 2'b00;
    endcase
    chk("gnt", {30'd0, gnt}, {30'd0, eg});
    if (eg != 2'b00) begin
      i = eg[1];
      m_last = i;
      e.rv = '0; e.er = '0;
      if (o[i] == 1'b0) begin
        if (m_stk.size() == DEPTH) begin
          e.er = eg; e.rd = m_rdata; rq.push_back(e);
        end else begin
          m_stk.push_back(i ? d1 : d0);
        end
      end else begin
        if (m_stk.size() == 0) begin
          e.er = eg; e.rd = m_rdata; rq.push_back(e);
        end else begin
          m_rdata = m_stk.pop_back();
          e.rv = eg; e.rd = m_rdata; rq.push_back(e);
        end
      end
    end
    @(posedge clk);
  endtask

  // Flush with requester 0 holding a push; abort_k >= 0 asserts reset in that drain cycle.
  task automatic do_flush(input int abort_k);
    int n;
    @(negedge clk); #1;
    chk_occ();
    req = 2'b01; op = 2'b00; wdata = {8'h00, 8'h55}; flush = 1'b1;
    #1;
    n = m_stk.size();
    chk("gnt_flush_start", {30'd0, gnt}, 0);
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      chk("busy_flush", {31'd0, busy}, 1);
      chk("gnt_flush", {30'd0, gnt}, 0);
      chk("count_flush", {28'd0, count}, n - k);
      if (k == abort_k) begin
        chk("drain_pending", dq.size(), 0);
        reset = 1'b1;
        m_stk.delete(); m_last = 1'b1; m_rdata = '0;
        @(posedge clk); #1;
        reset = 1'b0; req = '0; flush = 1'b0;
        @(negedge clk); #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_drain_valid", {31'd0, drain_valid}, 0);
        chk("abort_count", {28'd0, count}, 0);
        chk("abort_empty", {31'd0, empty}, 1);
        return;
      end
      dq.push_back(m_stk.pop_back());
      if (k == n - 1) flush = 1'b0;
      @(posedge clk);
    end
  endtask

  initial begin
    do_reset();

    // Requester 0 pushes three values, requester 1 pops them back in LIFO order.
    drive(2'b01, 2'b00, 8'h11, 8'h00);
    drive(2'b01, 2'b00, 8'h22, 8'h00);
    drive(2'b01, 2'b00, 8'h33, 8'h00);
    for (int k = 0; k < 3; k++) drive(2'b10, 2'b10, 8'h00, 8'h00);
    drive(2'b00, 2'b00, 8'h00, 8'h00);

    // Contention: both push every cycle, then fill to full and overflow.
    do_reset();
    for (int k = 0; k < 4; k++) drive(2'b11, 2'b00, 8'h40 + 8'(k), 8'h50 + 8'(k));
    for (int k = 0; k < 4; k++) drive(2'b01, 2'b00, 8'h60 + 8'(k), 8'h00);
    drive(2'b01, 2'b00, 8'hEE, 8'h00);
    drive(2'b00, 2'b00, 8'h00, 8'h00);

    // Drain by pops, then pop an empty stack.
    for (int k = 0; k < DEPTH; k++) drive(2'b01, 2'b01, 8'h00, 8'h00);
    drive(2'b10, 2'b10, 8'h00, 8'h00);
    drive(2'b00, 2'b00, 8'h00, 8'h00);

    // Mixed random traffic against the model.
    for (int k = 0; k < 40; k++)
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));

    // Flush on an empty stack does nothing.
    do_reset();
    @(negedge clk); #1;
    req = '0; flush = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    flush = 1'b0;
    chk("empty_flush_busy", {31'd0, busy}, 0);
    drive(2'b00, 2'b00, 8'h00, 8'h00);

    // Full flush of five entries, held request granted afterwards.
    for (int k = 0; k < 5; k++) drive(2'b01, 2'b00, 8'hA0 + 8'(k), 8'h00);
    do_flush(-1);
    drive(2'b01, 2'b00, 8'h55, 8'h00);

    // Reset in the third drain cycle, then requester 0 wins the first conflict.
    for (int k = 0; k < 5; k++) drive(2'b01, 2'b00, 8'hA0 + 8'(k), 8'h00);
    do_flush(2);
    drive(2'b11, 2'b00, 8'h77, 8'h88);
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    drive(2'b00, 2'b00, 8'h00, 8'h00);

    chk("pending_resp", rq.size(), 0);
    chk("pending_drain", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
